mult_seq_signed: RTL and testbench

MULT_SEQ_SIGNED -- requirements
Module: mult_seq_signed

---
 rtl/mult_seq_signed.sv | 98 +++++++++
 tb/tb_mult_seq_signed.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_signed.sv
// mult_seq_signed: sequential shift-and-add multiplier with signed/unsigned operands
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   start        begin a multiply (sampled only in IDLE)
//   signed_mode  1 = two's-complement operands, 0 = unsigned (sampled with start)
//   multiplier   N-bit multiplier operand (sampled with start)
//   multiplicand N-bit multiplicand operand (sampled with start)
//   ack          consumer acknowledge of the result (honoured only in DONE)
//   busy         high in CALC and DONE
//   valid        high only in DONE
//   product      registered 2N-bit result, updated only when CALC completes
module mult_seq_signed #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [N-1:0]   multiplier,
    input  logic [N-1:0]   multiplicand,
    input  logic           ack,
    output logic           busy,
    output logic           valid,
    output logic [2*N-1:0] product
);
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state;
    logic [N-1:0]   mplr;
    logic [2*N-1:0] mcand;
    logic [2*N-1:0] acc;
    logic [CW-1:0]  cnt;
    logic           sign;

    logic [N-1:0]   mag_a;
    logic [N-1:0]   mag_b;
    logic [2*N-1:0] acc_next;
    logic [N-1:0]   mplr_next;
    logic [CW-1:0]  cnt_next;
    logic           last;

    // Magnitudes are taken as unsigned N-bit values, so -2^(N-1) maps to 2^(N-1).
    always_comb begin
        mag_a     = (signed_mode && multiplier[N-1]) ? -multiplier : multiplier;
        mag_b     = (signed_mode && multiplicand[N-1]) ? -multiplicand : multiplicand;
        acc_next  = mplr[0] ? acc + mcand : acc;
        mplr_next = mplr >> 1;
        cnt_next  = cnt + 1'b1;
        // Stop once no multiplier bits remain, giving early termination.
        last      = (mplr_next == '0) || (cnt_next == CW'(N));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            mplr    <= '0;
            mcand   <= '0;
            acc     <= '0;
            cnt     <= '0;
            sign    <= 1'b0;
            busy    <= 1'b0;
            valid   <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= CALC;
                    mplr  <= mag_a;
                    mcand <= {{N{1'b0}}, mag_b};
                    acc   <= '0;
                    cnt   <= '0;
                    sign  <= signed_mode & (multiplier[N-1] ^ multiplicand[N-1]);
                    busy  <= 1'b1;
                end
                CALC: begin
                    acc   <= acc_next;
                    mplr  <= mplr_next;
                    mcand <= mcand << 1;
                    cnt   <= cnt_next;
                    if (last) begin
                        state   <= DONE;
                        valid   <= 1'b1;
                        product <= sign ? -acc_next : acc_next;
                    end
                end
                DONE: if (ack) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_seq_signed.sv
// tb_mult_seq_signed: directed table-driven bench for mult_seq_signed at N=8
module tb_mult_seq_signed;
    localparam int N = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           signed_mode;
    logic [N-1:0]   multiplier;
    logic [N-1:0]   multiplicand;
    logic           ack;
    logic           busy;
    logic           valid;
    logic [2*N-1:0] product;

    int errors = 0;
    int checks = 0;

    mult_seq_signed #(.N(N)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .signed_mode(signed_mode),
        .multiplier(multiplier),
        .multiplicand(multiplicand),
        .ack(ack),
        .busy(busy),
        .valid(valid),
        .product(product)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           sm;
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] exp_p;
        int             exp_c;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation and returns the number of CALC cycles seen before valid.
    task automatic launch(input logic sm, input logic [N-1:0] a, input logic [N-1:0] b,
                          output int cyc);
        signed_mode = sm;
        multiplier = a;
        multiplicand = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!valid && cyc < 100) begin
            cyc++;
            tick();
        end
    endtask

    initial begin
        int cyc;
        logic [2*N-1:0] held;
        vecs[0]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01, 8};
        vecs[1]  = '{1'b1, 8'h80, 8'h80, 16'h4000, 8};
        vecs[2]  = '{1'b1, 8'hFD, 8'h05, 16'hFFF1, 2};
        vecs[3]  = '{1'b0, 8'h00, 8'hAB, 16'h0000, 1};
        vecs[4]  = '{1'b0, 8'h04, 8'hAB, 16'h02AC, 3};
        vecs[5]  = '{1'b1, 8'h05, 8'hFD, 16'hFFF1, 3};
        vecs[6]  = '{1'b0, 8'h80, 8'h80, 16'h4000, 8};
        vecs[7]  = '{1'b1, 8'h7F, 8'h80, 16'hC080, 7};
        vecs[8]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001, 1};
        vecs[9]  = '{1'b0, 8'hFF, 8'h01, 16'h00FF, 8};
        vecs[10] = '{1'b1, 8'h00, 8'h80, 16'h0000, 1};
        vecs[11] = '{1'b0, 8'h0D, 8'h0B, 16'h008F, 4};

        reset = 1'b1;
        start = 1'b0;
        ack = 1'b0;
        signed_mode = 1'b0;
        multiplier = '0;
        multiplicand = '0;
        tick();
        tick();
        check("reset_busy", busy, 0);
        check("reset_valid", valid, 0);
        check("reset_product", product, 0);
        reset = 1'b0;
        ack = 1'b1;
        tick();
        check("idle_ack_ignored", busy, 0);
        ack = 1'b0;

        for (int i = 0; i < 12; i++) begin
            launch(vecs[i].sm, vecs[i].a, vecs[i].b, cyc);
            check($sformatf("v%0d_cycles", i), cyc, vecs[i].exp_c);
            check($sformatf("v%0d_product", i), product, vecs[i].exp_p);
            check($sformatf("v%0d_busy_done", i), busy, 1);
            ack = 1'b1;
            tick();
            ack = 1'b0;
            check($sformatf("v%0d_valid_after_ack", i), valid, 0);
            check($sformatf("v%0d_busy_after_ack", i), busy, 0);
            check($sformatf("v%0d_product_held", i), product, vecs[i].exp_p);
        end

        // Hold in DONE without ack for 10 cycles, then confirm product survives into IDLE.
        launch(1'b0, 8'hFF, 8'hFF, cyc);
        held = product;
        check("hold_product", held, 16'hFE01);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("hold_valid", valid, 1);
            check("hold_stable", product, 16'hFE01);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("hold_valid_cleared", valid, 0);
        tick();
        tick();
        check("hold_idle_product", product, 16'hFE01);

        // Reset during the 3rd CALC cycle abandons the operation and clears product.
        signed_mode = 1'b0;
        multiplier = 8'hFF;
        multiplicand = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("mid_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_reset_busy", busy, 0);
        check("mid_reset_valid", valid, 0);
        check("mid_reset_product", product, 0);
        tick();
        tick();
        check("mid_reset_stays_idle", busy, 0);

        // Start and ack during CALC are ignored; start+ack in DONE only returns to IDLE.
        signed_mode = 1'b0;
        multiplier = 8'h03;
        multiplicand = 8'h07;
        start = 1'b1;
        tick();
        multiplier = 8'hFF;
        multiplicand = 8'hFF;
        ack = 1'b1;
        cyc = 0;
        while (!valid && cyc < 100) begin
            cyc++;
            tick();
        end
        start = 1'b0;
        ack = 1'b0;
        check("ign_cycles", cyc, 2);
        check("ign_product", product, 16'h0015);
        start = 1'b1;
        ack = 1'b1;
        tick();
        start = 1'b0;
        ack = 1'b0;
        check("ign_done_valid", valid, 0);
        check("ign_done_busy", busy, 0);
        tick();
        tick();
        check("ign_no_new_op", busy, 0);
        check("ign_product_kept", product, 16'h0015);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
